// File: rtl/montgomery_convert.sv
// Montgomery-form converter: issues {R2 or 1, x} requests to the shared multiplier and
// re-attaches caller ctl/dir/err to the in-order results via a credit-limited tag FIFO.
module montgomery_convert #(
  parameter int                  DAT_BITS = 256,
  parameter int                  CTL_BITS = 8,
  parameter int                  MAX_OUT  = 8,
  parameter logic [DAT_BITS-1:0] P        = 256'h30644e72e131a029b85045b68181585d97816a916871ca8d3c208c16d87cfd47,
  parameter logic [DAT_BITS-1:0] R2       = 256'h06d89f71cab8351f47ab1eff0a417ff6b5e71911d44501fbf32cfc5b538afa89
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_val,
  input  logic [DAT_BITS-1:0]   i_dat,
  input  logic                  i_dir,
  input  logic [CTL_BITS-1:0]   i_ctl,
  output logic                  o_rdy,
  output logic                  o_mul_val,
  output logic [2*DAT_BITS-1:0] o_mul_dat,
  output logic [CTL_BITS-1:0]   o_mul_ctl,
  input  logic                  i_mul_rdy,
  input  logic                  i_res_val,
  input  logic [DAT_BITS-1:0]   i_res_dat,
  input  logic [CTL_BITS-1:0]   i_res_ctl,
  output logic                  o_res_rdy,
  output logic                  o_val,
  output logic [DAT_BITS-1:0]   o_dat,
  output logic [CTL_BITS-1:0]   o_ctl,
  output logic                  o_dir,
  output logic                  o_err,
  input  logic                  i_rdy
);

  localparam int PTR_BITS = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int CNT_BITS = PTR_BITS + 1;
  localparam int CTX_BITS = CTL_BITS + 2;

  logic [PTR_BITS-1:0] wr_ptr_reg;
  logic [PTR_BITS-1:0] rd_ptr_reg;
  logic [CNT_BITS-1:0] cnt_reg;
  logic [CNT_BITS-1:0] cnt_next;
  logic [CTX_BITS-1:0] ctx_mem [MAX_OUT];
  logic [CTX_BITS-1:0] ctx_rd;

  logic accept;
  logic deliver;
  logic res_fire;
  logic res_ok;
  logic res_bad;
  logic pending;
  logic tag_mismatch;

  assign o_rdy     = (cnt_reg < CNT_BITS'(MAX_OUT)) && (!o_mul_val || i_mul_rdy);
  assign o_res_rdy = !o_val || i_rdy;

  assign accept   = i_val && o_rdy;
  assign deliver  = o_val && i_rdy;
  assign res_fire = i_res_val && o_res_rdy;

  // cnt also covers the result sitting in the output register, so a response is only
  // legitimate while some slot beyond that one is still waiting on the multiplier.
  assign pending      = (cnt_reg != CNT_BITS'(o_val));
  assign res_ok       = res_fire && pending;
  assign res_bad      = res_fire && !pending;
  assign ctx_rd       = ctx_mem[rd_ptr_reg];
  assign tag_mismatch = (i_res_ctl[PTR_BITS-1:0] != rd_ptr_reg);

  always_ff @(posedge i_clk) begin
    if (accept) begin
      ctx_mem[wr_ptr_reg] <= {i_ctl, i_dir, (i_dat >= P)};
    end
  end

  always_comb begin
    cnt_next = cnt_reg;
    case ({accept, deliver})
      2'b10:   cnt_next = cnt_reg + 1'b1;
      2'b01:   cnt_next = cnt_reg - 1'b1;
      default: cnt_next = cnt_reg;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      cnt_reg    <= '0;
    end else begin
      cnt_reg <= cnt_next;
      if (accept) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (res_ok) rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  // Request register holds steady under multiplier backpressure; o_rdy guarantees an
  // accept never overwrites a request that has not been taken.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_mul_val <= 1'b0;
      o_mul_dat <= '0;
      o_mul_ctl <= '0;
    end else if (accept) begin
      o_mul_val <= 1'b1;
      o_mul_dat <= {(i_dir ? DAT_BITS'(1) : R2), i_dat};
      o_mul_ctl <= CTL_BITS'(wr_ptr_reg);
    end else if (i_mul_rdy) begin
      o_mul_val <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_val <= 1'b0;
      o_dat <= '0;
      o_ctl <= '0;
      o_dir <= 1'b0;
      o_err <= 1'b0;
    end else if (res_ok) begin
      o_val <= 1'b1;
      o_dat <= i_res_dat;
      o_ctl <= ctx_rd[CTX_BITS-1:2];
      o_dir <= ctx_rd[1];
      o_err <= ctx_rd[0] || tag_mismatch;
    end else if (res_bad) begin
      // Stray response: dropped, flagged with a one-cycle o_err pulse.
      o_val <= 1'b0;
      o_err <= 1'b1;
    end else if (o_res_rdy) begin
      o_val <= 1'b0;
      o_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_montgomery_convert.sv
// Self-checking bench for montgomery_convert: randomized operands through a behavioural
// Montgomery multiplier, results checked against plain modular arithmetic.
module tb_montgomery_convert;

  localparam logic [255:0] P_TB    = 256'h30644e72e131a029b85045b68181585d97816a916871ca8d3c208c16d87cfd47;
  localparam logic [511:0] R_MOD_W = (512'd1 << 256) % 512'(P_TB);
  localparam logic [255:0] R_MOD   = R_MOD_W[255:0];
  localparam logic [511:0] R2_W    = (R_MOD_W * R_MOD_W) % 512'(P_TB);
  localparam logic [255:0] R2_TB   = R2_W[255:0];

  logic         i_clk;
  logic         i_rst_n;
  logic         i_val;
  logic [255:0] i_dat;
  logic         i_dir;
  logic [7:0]   i_ctl;
  logic         o_rdy;
  logic         o_mul_val;
  logic [511:0] o_mul_dat;
  logic [7:0]   o_mul_ctl;
  logic         i_mul_rdy;
  logic         i_res_val;
  logic [255:0] i_res_dat;
  logic [7:0]   i_res_ctl;
  logic         o_res_rdy;
  logic         o_val;
  logic [255:0] o_dat;
  logic [7:0]   o_ctl;
  logic         o_dir;
  logic         o_err;
  logic         i_rdy;

  int checks = 0;
  int errors = 0;
  int mul_pct = 100;
  int res_pct = 100;
  int rdy_pct = 100;
  bit model_en = 1'b1;
  bit corrupt_tag = 1'b0;
  int mul_req_cnt = 0;
  int drive_cycles = 0;
  logic [255:0] last_dat;

  logic [255:0] mq_dat[$];
  logic [7:0]   mq_tag[$];
  logic [255:0] op_x[$];
  bit           op_dir[$];
  logic [7:0]   op_ctl[$];
  logic [255:0] ex_dat[$];
  bit           ex_err[$];

  montgomery_convert #(
    .DAT_BITS(256), .CTL_BITS(8), .MAX_OUT(8), .P(P_TB), .R2(R2_TB)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_val(i_val), .i_dat(i_dat), .i_dir(i_dir), .i_ctl(i_ctl), .o_rdy(o_rdy),
    .o_mul_val(o_mul_val), .o_mul_dat(o_mul_dat), .o_mul_ctl(o_mul_ctl), .i_mul_rdy(i_mul_rdy),
    .i_res_val(i_res_val), .i_res_dat(i_res_dat), .i_res_ctl(i_res_ctl), .o_res_rdy(o_res_rdy),
    .o_val(o_val), .o_dat(o_dat), .o_ctl(o_ctl), .o_dir(o_dir), .o_err(o_err), .i_rdy(i_rdy)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // a*b*R^-1 mod P by bit-serial reduction; only used as the multiplier stand-in.
  function automatic logic [255:0] fe_mul_mont(input logic [255:0] a, input logic [255:0] b);
    logic [513:0] t;
    t = 514'(a) * 514'(b);
    for (int i = 0; i < 256; i++) begin
      if (t[0]) t = t + 514'(P_TB);
      t = t >> 1;
    end
    while (t >= 514'(P_TB)) t = t - 514'(P_TB);
    return t[255:0];
  endfunction

  function automatic logic [255:0] to_mont(input logic [255:0] v);
    logic [511:0] m;
    m = (512'(v) * 512'(R_MOD)) % 512'(P_TB);
    return m[255:0];
  endfunction

  function automatic logic [255:0] rand_fe();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r % P_TB;
  endfunction

  // Multiplier model: in-order, random acceptance and return latency.
  initial begin
    i_mul_rdy = 1'b1;
    i_res_val = 1'b0;
    i_res_dat = '0;
    i_res_ctl = '0;
    forever begin
      @(negedge i_clk);
      if (!i_rst_n) begin
        mq_dat.delete();
        mq_tag.delete();
      end else begin
        if (model_en && i_res_val && o_res_rdy && mq_dat.size() > 0) begin
          void'(mq_dat.pop_front());
          void'(mq_tag.pop_front());
          corrupt_tag = 1'b0;
        end
        if (o_mul_val && i_mul_rdy) begin
          mq_dat.push_back(fe_mul_mont(o_mul_dat[255:0], o_mul_dat[511:256]));
          mq_tag.push_back(o_mul_ctl);
          mul_req_cnt++;
        end
      end
      @(posedge i_clk);
      #1;
      i_mul_rdy = (int'($urandom_range(99)) < mul_pct);
      if (model_en) begin
        if (mq_dat.size() > 0 && int'($urandom_range(99)) < res_pct) begin
          i_res_val = 1'b1;
          i_res_dat = mq_dat[0];
          i_res_ctl = mq_tag[0] ^ {7'd0, corrupt_tag};
        end else begin
          i_res_val = 1'b0;
          i_res_dat = '0;
          i_res_ctl = '0;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish, time=%0t required finish earlier", $time);
    $fatal(1);
  end

  task automatic add_op(input logic [255:0] x, input bit dir, input logic [7:0] ctl,
                        input logic [255:0] exd, input bit exe);
    op_x.push_back(x);
    op_dir.push_back(dir);
    op_ctl.push_back(ctl);
    ex_dat.push_back(exd);
    ex_err.push_back(exe);
  endtask

  task automatic add_rand_op(input logic [7:0] ctl);
    logic [255:0] v;
    v = rand_fe();
    if ($urandom_range(1) == 1) add_op(to_mont(v), 1'b1, ctl, v, 1'b0);
    else                        add_op(v, 1'b0, ctl, to_mont(v), 1'b0);
  endtask

  task automatic clear_ops();
    op_x.delete();
    op_dir.delete();
    op_ctl.delete();
    ex_dat.delete();
    ex_err.delete();
  endtask

  task automatic drive_ops();
    drive_cycles = 0;
    for (int k = 0; k < op_x.size(); k++) begin
      bit fired;
      fired = 1'b0;
      i_val = 1'b1;
      i_dat = op_x[k];
      i_dir = op_dir[k];
      i_ctl = op_ctl[k];
      for (int c = 0; c < 500 && !fired; c++) begin
        @(negedge i_clk);
        fired = o_rdy;
        drive_cycles++;
        @(posedge i_clk);
        #1;
      end
      checks++;
      if (!fired) begin
        errors++;
        $display("FAIL accept_timeout op %0d o_rdy=%0b required 1 within 500 cycles", k, o_rdy);
        i_val = 1'b0;
        return;
      end
    end
    i_val = 1'b0;
    i_dat = '0;
    i_dir = 1'b0;
    i_ctl = '0;
  endtask

  task automatic drain(input int n);
    int got;
    int cyc;
    got = 0;
    cyc = 0;
    while (got < n && cyc < n * 60 + 3000) begin
      @(negedge i_clk);
      cyc++;
      if (o_val && i_rdy) begin
        checks++;
        if (o_ctl !== op_ctl[got]) begin
          errors++;
          $display("FAIL result_ctl #%0d got %02h required %02h", got, o_ctl, op_ctl[got]);
        end
        checks++;
        if (o_dir !== op_dir[got]) begin
          errors++;
          $display("FAIL result_dir #%0d got %0b required %0b", got, o_dir, op_dir[got]);
        end
        checks++;
        if (o_err !== ex_err[got]) begin
          errors++;
          $display("FAIL result_err #%0d got %0b required %0b", got, o_err, ex_err[got]);
        end
        if (!ex_err[got]) begin
          checks++;
          if (o_dat !== ex_dat[got]) begin
            errors++;
            $display("FAIL result_dat #%0d got %h required %h", got, o_dat, ex_dat[got]);
          end
        end
        $display("result #%0d ctl=%02h dir=%0b err=%0b dat=%h", got, o_ctl, o_dir, o_err, o_dat);
        last_dat = o_dat;
        got++;
      end
      @(posedge i_clk);
      #1;
      i_rdy = (int'($urandom_range(99)) < rdy_pct);
    end
    checks++;
    if (got != n) begin
      errors++;
      $display("FAIL result_count got %0d required %0d", got, n);
    end
    i_rdy = 1'b1;
  endtask

  task automatic idle_check();
    int extra;
    extra = 0;
    i_rdy = 1'b1;
    repeat (20) begin
      @(negedge i_clk);
      if (o_val) extra++;
    end
    @(posedge i_clk);
    #1;
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL extra_results got %0d cycles with o_val required 0", extra);
    end
  endtask

  task automatic run_ops();
    int n;
    n = op_x.size();
    fork
      drive_ops();
      drain(n);
    join
    idle_check();
    clear_ops();
  endtask

  task automatic test_reset();
    i_rst_n = 1'b1;
    i_val = 1'b0; i_dat = '0; i_dir = 1'b0; i_ctl = '0; i_rdy = 1'b1;
    #1 i_rst_n = 1'b0;
    #2;
    checks++;
    if ({o_mul_val, o_val, o_err, o_dir} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags got mul_val/val/err/dir=%b required 0000", {o_mul_val, o_val, o_err, o_dir});
    end
    checks++;
    if (o_dat !== '0 || o_mul_dat !== '0 || o_ctl !== '0 || o_mul_ctl !== '0) begin
      errors++;
      $display("FAIL reset_data got dat=%h ctl=%h mul_ctl=%h required all 0", o_dat, o_ctl, o_mul_ctl);
    end
    repeat (3) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    checks++;
    if (o_rdy !== 1'b1 || o_res_rdy !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got o_rdy=%0b o_res_rdy=%0b required 1 1", o_rdy, o_res_rdy);
    end
    $display("reset done");
  endtask

  // Must run straight after a reset: tags are expected to start at 0.
  task automatic test_request_format();
    logic [255:0] x;
    logic [511:0] req_exp;
    mul_pct = 0;
    @(posedge i_clk);
    #1;
    for (int t = 0; t < 2; t++) begin
      if (t == 0) begin
        x = 256'd5;
        req_exp = {R2_TB, x};
        add_op(x, 1'b0, 8'h11, to_mont(x), 1'b0);
      end else begin
        x = to_mont(256'd9);
        req_exp = {256'd1, x};
        add_op(x, 1'b1, 8'h12, 256'd9, 1'b0);
      end
      i_val = 1'b1; i_dat = x; i_dir = t[0]; i_ctl = op_ctl[0];
      @(negedge i_clk);
      checks++;
      if (o_rdy !== 1'b1) begin
        errors++;
        $display("FAIL req_accept #%0d o_rdy=%0b required 1", t, o_rdy);
      end
      @(posedge i_clk);
      #1;
      i_val = 1'b0;
      checks++;
      if (o_mul_val !== 1'b1 || o_mul_dat !== req_exp || o_mul_ctl !== 8'(t)) begin
        errors++;
        $display("FAIL req_format #%0d got val=%0b ctl=%0d dat=%h required val=1 ctl=%0d dat=%h",
                 t, o_mul_val, o_mul_ctl, o_mul_dat, t, req_exp);
      end
      repeat (3) @(posedge i_clk);
      #1;
      checks++;
      if (o_mul_val !== 1'b1 || o_mul_dat !== req_exp || o_mul_ctl !== 8'(t)) begin
        errors++;
        $display("FAIL req_hold #%0d got val=%0b ctl=%0d required val=1 ctl=%0d, stable data",
                 t, o_mul_val, o_mul_ctl, t);
      end
      $display("request #%0d tag=%0d b=%h", t, o_mul_ctl, o_mul_dat[511:256]);
      mul_pct = 100;
      drain(1);
      clear_ops();
      mul_pct = 0;
      @(posedge i_clk);
      #1;
    end
    mul_pct = 100;
    idle_check();
  endtask

  task automatic test_round_trip();
    add_op(256'd5, 1'b0, 8'h01, to_mont(256'd5), 1'b0);
    run_ops();
    add_op(last_dat, 1'b1, 8'h02, 256'd5, 1'b0);
    run_ops();
  endtask

  task automatic test_special();
    add_op(256'd1, 1'b0, 8'h21, R_MOD, 1'b0);
    add_op(256'd0, 1'b0, 8'h22, 256'd0, 1'b0);
    add_op(256'd0, 1'b1, 8'h23, 256'd0, 1'b0);
    add_op(P_TB - 256'd1, 1'b0, 8'h24, to_mont(P_TB - 256'd1), 1'b0);
    run_ops();
  endtask

  task automatic test_back_to_back();
    mul_pct = 100; res_pct = 100; rdy_pct = 100;
    for (int k = 0; k < 40; k++) add_rand_op(8'(k));
    run_ops();
    checks++;
    if (drive_cycles != 40) begin
      errors++;
      $display("FAIL throughput got %0d cycles for 40 operands required 40", drive_cycles);
    end
  endtask

  task automatic test_credits();
    int req0;
    mul_pct = 100; res_pct = 100; rdy_pct = 0;
    i_rdy = 1'b0;
    req0 = mul_req_cnt;
    for (int k = 0; k < 10; k++) add_rand_op(8'(k));
    fork
      drive_ops();
      begin
        repeat (30) @(negedge i_clk);
        checks++;
        if (mul_req_cnt - req0 != 8) begin
          errors++;
          $display("FAIL credit_requests got %0d required 8", mul_req_cnt - req0);
        end
        checks++;
        if (o_rdy !== 1'b0) begin
          errors++;
          $display("FAIL credit_stall o_rdy=%0b required 0", o_rdy);
        end
        @(posedge i_clk);
        #1;
        rdy_pct = 100;
        drain(10);
      end
    join
    checks++;
    if (mul_req_cnt - req0 != 10) begin
      errors++;
      $display("FAIL credit_total got %0d requests required 10", mul_req_cnt - req0);
    end
    idle_check();
    clear_ops();
  endtask

  task automatic test_backpressure();
    mul_pct = 60; res_pct = 60; rdy_pct = 50;
    for (int k = 0; k < 300; k++) add_rand_op(8'(k));
    run_ops();
    mul_pct = 100; res_pct = 100; rdy_pct = 100;
  endtask

  task automatic test_error();
    add_op(P_TB, 1'b0, 8'h3C, 256'd0, 1'b1);
    add_op(256'd2, 1'b0, 8'h3D, to_mont(256'd2), 1'b0);
    add_op({256{1'b1}}, 1'b1, 8'h3E, 256'd0, 1'b1);
    add_op(256'd3, 1'b1, 8'h3F, fe_mul_mont(256'd3, 256'd1), 1'b0);
    run_ops();
    corrupt_tag = 1'b1;
    add_op(256'd7, 1'b0, 8'h44, to_mont(256'd7), 1'b1);
    run_ops();
    corrupt_tag = 1'b0;
    add_op(256'd8, 1'b0, 8'h45, to_mont(256'd8), 1'b0);
    run_ops();
  endtask

  task automatic test_violation();
    model_en = 1'b0;
    @(posedge i_clk);
    #1;
    i_res_val = 1'b1;
    i_res_dat = rand_fe();
    i_res_ctl = 8'h00;
    @(posedge i_clk);
    #1;
    i_res_val = 1'b0;
    checks++;
    if (o_val !== 1'b0 || o_err !== 1'b1) begin
      errors++;
      $display("FAIL stray_pulse got o_val=%0b o_err=%0b required 0 1", o_val, o_err);
    end
    @(posedge i_clk);
    #1;
    checks++;
    if (o_err !== 1'b0) begin
      errors++;
      $display("FAIL stray_clear got o_err=%0b required 0", o_err);
    end
    $display("stray response flagged");
    model_en = 1'b1;
    @(posedge i_clk);
    #1;
    add_rand_op(8'h50);
    add_rand_op(8'h51);
    run_ops();
  endtask

  task automatic test_reset_mid();
    mul_pct = 100; res_pct = 100; rdy_pct = 0;
    i_rdy = 1'b0;
    for (int k = 0; k < 4; k++) add_rand_op(8'(k));
    drive_ops();
    repeat (5) @(posedge i_clk);
    #1;
    checks++;
    if (o_val !== 1'b1) begin
      errors++;
      $display("FAIL midreset_busy got o_val=%0b required 1", o_val);
    end
    i_rst_n = 1'b0;
    #1;
    checks++;
    if ({o_mul_val, o_val, o_err, o_dir} !== 4'b0000 || o_dat !== '0 || o_ctl !== '0 ||
        o_mul_dat !== '0 || o_mul_ctl !== '0) begin
      errors++;
      $display("FAIL midreset_outputs got val=%0b mul_val=%0b err=%0b dat=%h required all 0",
               o_val, o_mul_val, o_err, o_dat);
    end
    clear_ops();
    repeat (3) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    rdy_pct = 100;
    i_rdy = 1'b1;
    @(posedge i_clk);
    #1;
    checks++;
    if (o_rdy !== 1'b1 || o_val !== 1'b0) begin
      errors++;
      $display("FAIL midreset_release got o_rdy=%0b o_val=%0b required 1 0", o_rdy, o_val);
    end
    $display("mid-operation reset done");
    test_request_format();
  endtask

  initial begin
    test_reset();
    test_request_format();
    test_round_trip();
    test_special();
    test_back_to_back();
    test_credits();
    test_backpressure();
    test_error();
    test_violation();
    test_reset_mid();
    test_backpressure();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
